// File: rtl/bullet_motion_pkg.sv
// Shared constants, state type and helpers for the bullet motion controller.
package bullet_motion_pkg;

  localparam int unsigned BULLET_WIDTH  = 4;
  localparam int unsigned BULLET_HEIGHT = 16;

  localparam logic [10:0] BULLET_PARK_X = 11'h7FF;
  localparam logic [9:0]  BULLET_PARK_Y = 10'h3FF;

  typedef enum logic [1:0] {
    BmIdle,
    BmArmed,
    BmFlying,
    BmCooldown
  } bm_state_e;

  // Widened to 11 bits so a shooter too close to the top shows up as a borrow in bit 10.
  function automatic logic [10:0] spawn_y_wide(input logic [9:0] shooter_y);
    return {1'b0, shooter_y} - 11'(BULLET_HEIGHT + 1);
  endfunction

endpackage

// File: rtl/bullet_motion_if.sv
// Control and position bundle between the shooter/collision logic and bullet_motion.
interface bullet_motion_if;

  logic        frame_tick;
  logic        fire;
  logic        hit;
  logic [10:0] shooter_x;
  logic [9:0]  shooter_y;
  logic [10:0] bullet_pos_x;
  logic [9:0]  bullet_pos_y;
  logic        bullet_active;
  logic        ready;

  modport master (
    output frame_tick, fire, hit, shooter_x, shooter_y,
    input  bullet_pos_x, bullet_pos_y, bullet_active, ready
  );

  modport slave (
    input  frame_tick, fire, hit, shooter_x, shooter_y,
    output bullet_pos_x, bullet_pos_y, bullet_active, ready
  );

endinterface

// File: rtl/bullet_motion_cooldown.sv
// Loadable down-counter stepped by frame_tick; flags zero and the final count.
module bullet_motion_cooldown #(
  parameter int unsigned Width = 4
) (
  input  logic             pixclk,
  input  logic             rst,
  input  logic             frame_tick_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (frame_tick_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign last_o = (count_q == Width'(1));

endmodule

// File: rtl/bullet_motion.sv
// Single-bullet motion controller: spawns on fire, climbs once per frame, parks when retired.
module bullet_motion import bullet_motion_pkg::*; #(
  parameter int unsigned SPEED           = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned X_OFFSET        = 12
) (
  input logic            pixclk,
  input logic            rst,
  bullet_motion_if.slave bus
);

  localparam int unsigned CntW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [9:0]  SpeedY = 10'(SPEED);
  localparam logic [10:0] XOff   = 11'(X_OFFSET);

  bm_state_e   state_q, state_d;
  logic [10:0] pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic        active_q, active_d;
  logic        ready_q, ready_d;

  logic        spawn, advance, retire;
  logic        cd_zero, cd_last;
  logic [10:0] spawn_y_w;

  assign spawn_y_w = spawn_y_wide(bus.shooter_y);

  bullet_motion_cooldown #(
    .Width (CntW)
  ) u_cooldown (
    .pixclk       (pixclk),
    .rst          (rst),
    .frame_tick_i (bus.frame_tick),
    .load_i       (retire),
    .load_val_i   (CntW'(COOLDOWN_FRAMES)),
    .zero_o       (cd_zero),
    .last_o       (cd_last)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    spawn   = 1'b0;
    advance = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      BmIdle: begin
        if (bus.fire) state_d = BmArmed;
      end
      BmArmed: begin
        if (bus.frame_tick) begin
          if (!spawn_y_w[10]) begin
            spawn   = 1'b1;
            state_d = BmFlying;
          end else begin
            state_d = BmIdle;
          end
        end
      end
      BmFlying: begin
        // hit wins over a coincident tick so the bullet never steps past its target.
        if (bus.hit) begin
          retire = 1'b1;
        end else if (bus.frame_tick) begin
          if (pos_y_q >= SpeedY) advance = 1'b1;
          else                   retire  = 1'b1;
        end
        if (retire) state_d = (COOLDOWN_FRAMES == 0) ? BmIdle : BmCooldown;
      end
      BmCooldown: begin
        if (cd_zero || (bus.frame_tick && cd_last)) state_d = BmIdle;
      end
      default: state_d = BmIdle;
    endcase
  end

  // Output next values, registered alongside the state.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (spawn) begin
      pos_x_d = bus.shooter_x + XOff;
      pos_y_d = spawn_y_w[9:0];
    end else if (advance) begin
      pos_y_d = pos_y_q - SpeedY;
    end else if (retire) begin
      pos_x_d = BULLET_PARK_X;
      pos_y_d = BULLET_PARK_Y;
    end
    active_d = (state_d == BmFlying);
    ready_d  = (state_d == BmIdle);
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state_q  <= BmIdle;
      pos_x_q  <= BULLET_PARK_X;
      pos_y_q  <= BULLET_PARK_Y;
      active_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      active_q <= active_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.bullet_pos_x  = pos_x_q;
  assign bus.bullet_pos_y  = pos_y_q;
  assign bus.bullet_active = active_q;
  assign bus.ready         = ready_q;

endmodule
